// File: rtl/ctrl_pipe_if.sv
// Handshake bundle between the ID-stage decoder / datapath and the ctrl_pipe control pipeline.
// The master drives decoder outputs and the EX zero flag; the slave (ctrl_pipe) returns stage controls.
interface ctrl_pipe_if #(
   parameter int unsigned RA_W = 5
);
   logic            id_regDst;
   logic            id_aluSrc;
   logic            id_memtoReg;
   logic            id_regWrite;
   logic            id_memRead;
   logic            id_memWrite;
   logic            id_branch;
   logic            id_BranchN;
   logic            id_signZero;
   logic            id_jmp;
   logic [2:0]      id_aluop;
   logic [RA_W-1:0] id_rs;
   logic [RA_W-1:0] id_rt;
   logic [RA_W-1:0] id_rd;
   logic            ex_zero;

   logic            ex_aluSrc;
   logic            ex_signZero;
   logic [2:0]      ex_aluop;
   logic [RA_W-1:0] ex_dst;
   logic            mem_memRead;
   logic            mem_memWrite;
   logic [RA_W-1:0] mem_dst;
   logic            wb_regWrite;
   logic            wb_memtoReg;
   logic [RA_W-1:0] wb_dst;
   logic            pc_write;
   logic            ifid_write;
   logic            ifid_flush;
   logic            br_taken;
   logic            jmp_take;

   modport master (
      output id_regDst, id_aluSrc, id_memtoReg, id_regWrite, id_memRead, id_memWrite,
             id_branch, id_BranchN, id_signZero, id_jmp, id_aluop, id_rs, id_rt, id_rd,
             ex_zero,
      input  ex_aluSrc, ex_signZero, ex_aluop, ex_dst, mem_memRead, mem_memWrite, mem_dst,
             wb_regWrite, wb_memtoReg, wb_dst, pc_write, ifid_write, ifid_flush, br_taken,
             jmp_take
   );

   modport slave (
      input  id_regDst, id_aluSrc, id_memtoReg, id_regWrite, id_memRead, id_memWrite,
             id_branch, id_BranchN, id_signZero, id_jmp, id_aluop, id_rs, id_rt, id_rd,
             ex_zero,
      output ex_aluSrc, ex_signZero, ex_aluop, ex_dst, mem_memRead, mem_memWrite, mem_dst,
             wb_regWrite, wb_memtoReg, wb_dst, pc_write, ifid_write, ifid_flush, br_taken,
             jmp_take
   );
endinterface

// File: rtl/ctrl_pipe.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall, EX branch resolution,
// ID jump acceptance and the resulting PC / IF-ID write-enable and flush controls.
module ctrl_pipe #(
   parameter int unsigned RA_W = 5
) (
   input logic        clk,
   input logic        rst,
   ctrl_pipe_if.slave bus
);

   typedef struct packed {
      logic            regdst;
      logic            alusrc;
      logic            memtoreg;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            branch;
      logic            branchn;
      logic            signzero;
      logic [2:0]      aluop;
      logic [RA_W-1:0] rt;
      logic [RA_W-1:0] rd;
   } ex_t;

   typedef struct packed {
      logic            memtoreg;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic [RA_W-1:0] dst;
   } mem_t;

   typedef struct packed {
      logic            memtoreg;
      logic            regwrite;
      logic [RA_W-1:0] dst;
   } wb_t;

   ex_t             ex_q, ex_d, id_bundle;
   mem_t            mem_q, mem_d;
   wb_t             wb_q, wb_d;
   logic [RA_W-1:0] ex_dst;
   logic            stall, br_taken, jmp_take;

   always_comb begin
      id_bundle          = '0;
      id_bundle.regdst   = bus.id_regDst;
      id_bundle.alusrc   = bus.id_aluSrc;
      id_bundle.memtoreg = bus.id_memtoReg;
      id_bundle.regwrite = bus.id_regWrite;
      id_bundle.memread  = bus.id_memRead;
      id_bundle.memwrite = bus.id_memWrite;
      id_bundle.branch   = bus.id_branch;
      id_bundle.branchn  = bus.id_BranchN;
      id_bundle.signzero = bus.id_signZero;
      id_bundle.aluop    = bus.id_aluop;
      id_bundle.rt       = bus.id_rt;
      id_bundle.rd       = bus.id_rd;
   end

   assign ex_dst = ex_q.regdst ? ex_q.rd : ex_q.rt;

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   assign stall = ex_q.memread & (ex_q.rt != '0) &
                  ((ex_q.rt == bus.id_rs) | (ex_q.rt == bus.id_rt));
   assign br_taken = (ex_q.branch & bus.ex_zero) | (ex_q.branchn & ~bus.ex_zero);
   assign jmp_take = bus.id_jmp & ~stall & ~br_taken;

   always_comb begin
      ex_d           = (br_taken | stall) ? '0 : id_bundle;
      mem_d          = '0;
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memread  = ex_q.memread;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.dst      = ex_dst;
      wb_d           = '0;
      wb_d.memtoreg  = mem_q.memtoreg;
      wb_d.regwrite  = mem_q.regwrite;
      wb_d.dst       = mem_q.dst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign bus.ex_aluSrc    = ex_q.alusrc;
   assign bus.ex_signZero  = ex_q.signzero;
   assign bus.ex_aluop     = ex_q.aluop;
   assign bus.ex_dst       = ex_dst;
   assign bus.mem_memRead  = mem_q.memread;
   assign bus.mem_memWrite = mem_q.memwrite;
   assign bus.mem_dst      = mem_q.dst;
   assign bus.wb_regWrite  = wb_q.regwrite;
   assign bus.wb_memtoReg  = wb_q.memtoreg;
   assign bus.wb_dst       = wb_q.dst;

   // A taken branch overrides the stall: the load-use consumer is being squashed anyway.
   assign bus.pc_write   = ~(stall & ~br_taken);
   assign bus.ifid_write = ~(stall & ~br_taken);
   assign bus.ifid_flush = br_taken | jmp_take;
   assign bus.br_taken   = br_taken;
   assign bus.jmp_take   = jmp_take;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed hazard/branch/jump scenarios followed by random
// traffic, all compared against a stage-history reference model.
module tb_ctrl_pipe;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic       branchn;
      logic       signzero;
      logic [2:0] aluop;
      logic [4:0] rt;
      logic [4:0] rd;
   } ctl_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   // hist[0] is the instruction in EX, hist[1] in MEM, hist[2] in WB.
   ctl_t       hist [3];
   ctl_t       cur_id;
   logic [4:0] cur_rs;
   logic       cur_jmp, cur_z;

   ctrl_pipe_if #(.RA_W(5)) bus ();

   ctrl_pipe #(.RA_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input ctl_t c, input logic [4:0] rs, input logic jmp, input logic z);
      cur_id = c; cur_rs = rs; cur_jmp = jmp; cur_z = z;
      bus.id_regDst   = c.regdst;
      bus.id_aluSrc   = c.alusrc;
      bus.id_memtoReg = c.memtoreg;
      bus.id_regWrite = c.regwrite;
      bus.id_memRead  = c.memread;
      bus.id_memWrite = c.memwrite;
      bus.id_branch   = c.branch;
      bus.id_BranchN  = c.branchn;
      bus.id_signZero = c.signzero;
      bus.id_aluop    = c.aluop;
      bus.id_rt       = c.rt;
      bus.id_rd       = c.rd;
      bus.id_rs       = rs;
      bus.id_jmp      = jmp;
      bus.ex_zero     = z;
   endtask

   function automatic ctl_t rand_ctl();
      ctl_t c;
      c         = ctl_t'($urandom);
      c.rt      = 5'($urandom_range(0, 3));
      c.memread = ($urandom_range(0, 2) == 0);
      c.branch  = ($urandom_range(0, 5) == 0);
      c.branchn = ($urandom_range(0, 5) == 0);
      return c;
   endfunction

   function automatic logic [4:0] dst_of(input ctl_t c);
      return c.regdst ? c.rd : c.rt;
   endfunction

   // Check every output against the model, then advance one clock and update the model.
   task automatic step();
      ctl_t ex;
      logic hazard, br, jt;
      #1;
      ex     = hist[0];
      hazard = ex.memread && (ex.rt != 0) && (ex.rt == cur_rs || ex.rt == cur_id.rt);
      br     = cur_z ? ex.branch : ex.branchn;
      jt     = cur_jmp && !hazard && !br;
      chk("ex_aluSrc",    bus.ex_aluSrc,    ex.alusrc);
      chk("ex_signZero",  bus.ex_signZero,  ex.signzero);
      chk("ex_aluop",     bus.ex_aluop,     ex.aluop);
      chk("ex_dst",       bus.ex_dst,       dst_of(ex));
      chk("mem_memRead",  bus.mem_memRead,  hist[1].memread);
      chk("mem_memWrite", bus.mem_memWrite, hist[1].memwrite);
      chk("mem_dst",      bus.mem_dst,      dst_of(hist[1]));
      chk("wb_regWrite",  bus.wb_regWrite,  hist[2].regwrite);
      chk("wb_memtoReg",  bus.wb_memtoReg,  hist[2].memtoreg);
      chk("wb_dst",       bus.wb_dst,       dst_of(hist[2]));
      chk("br_taken",     bus.br_taken,     br);
      chk("jmp_take",     bus.jmp_take,     jt);
      chk("pc_write",     bus.pc_write,     !(hazard && !br));
      chk("ifid_write",   bus.ifid_write,   !(hazard && !br));
      chk("ifid_flush",   bus.ifid_flush,   br || jt);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 3; i++) hist[i] = '0;
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = (br || hazard) ? ctl_t'(0) : cur_id;
      end
      #1;
   endtask

   initial begin
      ctl_t nop, rtype, lw, add, beq, jmpi;
      nop = '0;
      rtype = '0; rtype.aluop = 3'b010; rtype.regwrite = 1'b1; rtype.memtoreg = 1'b1;
      rtype.regdst = 1'b1; rtype.rd = 5'd5; rtype.rt = 5'd7;
      lw = '0; lw.memread = 1'b1; lw.regwrite = 1'b1; lw.alusrc = 1'b1; lw.rt = 5'd3;
      add = rtype; add.rd = 5'd9; add.rt = 5'd1;
      beq = '0; beq.branch = 1'b1; beq.aluop = 3'b001; beq.rt = 5'd2;
      jmpi = '0;
      for (int i = 0; i < 3; i++) hist[i] = '0;

      // Reset: two cycles of random inputs; first edge brings registers out of X.
      rst = 1'b1;
      drive(rand_ctl(), 5'($urandom), 1'b0, 1'($urandom));
      @(posedge clk);
      #1;
      drive(rand_ctl(), 5'($urandom), 1'b0, 1'($urandom));
      step();
      rst = 1'b0;
      drive(nop, 5'd0, 1'b0, 1'b0);
      #1;
      chk("rst_ex_aluop", bus.ex_aluop, 3'b000);
      chk("rst_wb_regWrite", bus.wb_regWrite, 1'b0);
      chk("rst_pc_write", bus.pc_write, 1'b1);
      chk("rst_ifid_flush", bus.ifid_flush, 1'b0);

      // R-type latency.
      drive(rtype, 5'd1, 1'b0, 1'b0);
      step();
      chk("rtype_ex_aluop", bus.ex_aluop, 3'b010);
      chk("rtype_ex_dst", bus.ex_dst, 5'd5);
      drive(nop, 5'd0, 1'b0, 1'b0);
      step();
      step();
      chk("rtype_wb_regWrite", bus.wb_regWrite, 1'b1);
      chk("rtype_wb_dst", bus.wb_dst, 5'd5);
      step();

      // Load-use stall on rt=3, then no stall with rt=0.
      for (int k = 0; k < 2; k++) begin
         lw.rt = (k == 0) ? 5'd3 : 5'd0;
         drive(lw, 5'd8, 1'b0, 1'b0);
         step();
         drive(add, lw.rt, 1'b0, 1'b0);
         #1;
         chk("lu_pc_write", bus.pc_write, (k == 0) ? 1'b0 : 1'b1);
         chk("lu_ifid_write", bus.ifid_write, (k == 0) ? 1'b0 : 1'b1);
         step();
         if (k == 0) begin
            chk("lu_bubble_aluop", bus.ex_aluop, 3'b000);
            step();
         end
         chk("lu_add_in_ex", bus.ex_aluop, 3'b010);
         drive(nop, 5'd0, 1'b0, 1'b0);
         step();
      end
      lw.rt = 5'd3;

      // beq / BranchN with both zero-flag polarities.
      for (int k = 0; k < 4; k++) begin
         beq.branch  = (k < 2);
         beq.branchn = (k >= 2);
         drive(beq, 5'd1, 1'b0, 1'b0);
         step();
         drive(rtype, 5'd1, 1'b0, 1'((k % 2) == 0));
         #1;
         chk("br_taken_dir", bus.br_taken, 1'(k == 0 || k == 3));
         chk("br_flush_dir", bus.ifid_flush, 1'(k == 0 || k == 3));
         step();
         chk("br_next_ex", bus.ex_aluop, (k == 0 || k == 3) ? 3'b000 : 3'b010);
         drive(nop, 5'd0, 1'b0, 1'b0);
         step();
      end

      // Jump held behind a load-use stall.
      lw.rt = 5'd4;
      drive(lw, 5'd0, 1'b0, 1'b0);
      step();
      drive(jmpi, 5'd4, 1'b1, 1'b0);
      #1;
      chk("jmp_stall_take", bus.jmp_take, 1'b0);
      step();
      chk("jmp_after_take", bus.jmp_take, 1'b1);
      chk("jmp_after_flush", bus.ifid_flush, 1'b1);
      step();

      // Jump in ID with a taken branch in EX.
      beq.branch = 1'b1; beq.branchn = 1'b0;
      drive(beq, 5'd0, 1'b0, 1'b0);
      step();
      drive(jmpi, 5'd0, 1'b1, 1'b1);
      #1;
      chk("jb_br_taken", bus.br_taken, 1'b1);
      chk("jb_jmp_take", bus.jmp_take, 1'b0);
      step();

      // Reset asserted during a stall clears it.
      drive(lw, 5'd0, 1'b0, 1'b0);
      step();
      drive(add, 5'd4, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rst_stall_cleared", bus.pc_write, 1'b1);
      step();

      // Random traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 31) == 0);
         drive(rand_ctl(), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
               1'($urandom));
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
